// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Purpose:
//   Register file with a per-register write-reservation scoreboard. Issue
//   reads operands, checks whether they are still being produced, and
//   reserves its destination with a tag. Writeback returns results with the
//   same tag. A writeback clears the reservation only when its tag matches,
//   so a stale writeback cannot release a newer reservation.
//   Register 0 is hardwired to zero and is never reserved.
//
// Optional feature (compile-time macro REGFILE_WB_BYPASS_EN):
//   When defined, a read port addressing the register targeted by a
//   qualifying writeback sees wb_data_i in the same cycle, with busy = 0.
//   When undefined, reads show only the registered state.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-low reset
//   rd_addr_i    in   N_RD read addresses, port k at [k*A_REG +: A_REG]
//   rd_data_o    out  read data, port k at [k*W_DATA +: W_DATA]
//   rd_busy_o    out  reservation bit of the addressed register, per port
//   rd_tag_o     out  reservation tag of the addressed register, per port
//   res_valid_i  in   reserve res_addr_i this cycle
//   res_addr_i   in   register to reserve
//   res_tag_i    in   tag of the producing instruction
//   wb_valid_i   in   writeback this cycle
//   wb_addr_i    in   writeback register
//   wb_tag_i     in   writeback tag
//   wb_data_i    in   writeback data
//   flush_i      in   clear all reservations
//   busy_cnt_o   out  number of registers currently reserved (registered)
//
// Handshake: there is no back-pressure. A reservation or writeback is
// accepted on every rising edge where its valid is high; the address, tag
// and data alongside a low valid are ignored.
// -----------------------------------------------------------------------------
`default_nettype none

module regfile_scoreboard #(
  parameter int W_DATA = 32,
  parameter int N_REG  = 32,
  parameter int A_REG  = 5,
  parameter int N_RD   = 2,
  parameter int W_TAG  = 4,
  parameter int W_CNT  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_RD*A_REG-1:0]   rd_addr_i,
  output logic [N_RD*W_DATA-1:0]  rd_data_o,
  output logic [N_RD-1:0]         rd_busy_o,
  output logic [N_RD*W_TAG-1:0]   rd_tag_o,
  input  logic                    res_valid_i,
  input  logic [A_REG-1:0]        res_addr_i,
  input  logic [W_TAG-1:0]        res_tag_i,
  input  logic                    wb_valid_i,
  input  logic [A_REG-1:0]        wb_addr_i,
  input  logic [W_TAG-1:0]        wb_tag_i,
  input  logic [W_DATA-1:0]       wb_data_i,
  input  logic                    flush_i,
  output logic [W_CNT-1:0]        busy_cnt_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N_REG-1:0][W_DATA-1:0] r_data;
  logic [N_REG-1:0]             r_busy;
  logic [N_REG-1:0][W_TAG-1:0]  r_tag;
  logic [W_CNT-1:0]             r_cnt;

  // ---------------------------------------------------------------------------
  // Request qualification (address 0 is never a target)
  // ---------------------------------------------------------------------------
  logic w_res_en;
  logic w_wb_en;
  logic w_wb_match;
  logic w_wb_write;
  logic w_wb_clear;

  assign w_res_en   = res_valid_i && (res_addr_i != '0);
  assign w_wb_en    = wb_valid_i  && (wb_addr_i  != '0);

  // Evaluated against the pre-edge state, so a same-cycle reservation of the
  // same register does not affect whether this writeback qualifies.
  assign w_wb_match = r_busy[wb_addr_i] && (r_tag[wb_addr_i] == wb_tag_i);
  assign w_wb_write = w_wb_en && (w_wb_match || !r_busy[wb_addr_i]);
  assign w_wb_clear = w_wb_en && w_wb_match;

  // ---------------------------------------------------------------------------
  // Next busy vector and its population count
  // Order of precedence: flush, then writeback clear, then reservation set.
  // The reservation is applied last so it wins over both flush and a
  // same-address writeback.
  // ---------------------------------------------------------------------------
  logic [N_REG-1:0] w_busy_nxt;
  logic [W_CNT-1:0] w_cnt_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (flush_i) begin
      w_busy_nxt = '0;
    end
    if (w_wb_clear) begin
      w_busy_nxt[wb_addr_i] = 1'b0;
    end
    if (w_res_en) begin
      w_busy_nxt[res_addr_i] = 1'b1;
    end
  end

  // Count is derived from the next busy state rather than tracked with
  // increments/decrements, so re-reservations and flushes cannot skew it.
  // Bit 0 is never set, so the sum is bounded by N_REG-1.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 1; i < N_REG; i++) begin
      w_cnt_nxt = w_cnt_nxt + W_CNT'(w_busy_nxt[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_busy <= '0;
      r_tag  <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_wb_write) begin
        r_data[wb_addr_i] <= wb_data_i;
      end
      if (w_res_en) begin
        r_tag[res_addr_i] <= res_tag_i;
      end
    end
  end

  assign busy_cnt_o = r_cnt;

  // ---------------------------------------------------------------------------
  // Read ports
  // Entry 0 of data/busy/tag is reset to zero and never written, so a plain
  // array lookup already returns zero / not-busy for register 0.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [A_REG-1:0] w_addr;
    assign w_addr = rd_addr_i[k*A_REG +: A_REG];

`ifdef REGFILE_WB_BYPASS_EN
    // w_wb_write already excludes address 0. A qualifying writeback either
    // matches (and clears busy) or targets a non-busy register, so the
    // forwarded busy bit is always 0.
    logic w_hit;
    assign w_hit = w_wb_write && (w_addr == wb_addr_i);

    assign rd_data_o[k*W_DATA +: W_DATA] = w_hit ? wb_data_i : r_data[w_addr];
    assign rd_busy_o[k]                  = w_hit ? 1'b0      : r_busy[w_addr];
`else
    assign rd_data_o[k*W_DATA +: W_DATA] = r_data[w_addr];
    assign rd_busy_o[k]                  = r_busy[w_addr];
`endif
    assign rd_tag_o[k*W_TAG +: W_TAG]    = r_tag[w_addr];
  end

endmodule

`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised register file with a per-register write-reservation scoreboard. It generalises the single-cell reserve/writeback scheme to N_REG entries, N_RD read ports and tagged reservations.
- Sits between decode/issue (reads operands, checks busy, reserves the destination) and the writeback stage (returns results with a tag).
- A tag match prevents a stale writeback from clearing a newer reservation.

Parameters:
- W_DATA, 32, data width per register
- N_REG, 32, number of registers (power of 2)
- A_REG, 5, register address width, log2(N_REG)
- N_RD, 2, number of read ports
- W_TAG, 4, reservation tag width
- W_CNT, 6, busy-counter width, log2(N_REG)+1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rd_addr_i  in  N_RD*A_REG  read addresses, port k at bits [k*A_REG +: A_REG]
- rd_data_o  out  N_RD*W_DATA  read data per port
- rd_busy_o  out  N_RD  reservation bit of the addressed register, per port
- rd_tag_o  out  N_RD*W_TAG  current reservation tag of the addressed register
- res_valid_i  in  1  reserve the destination register this cycle
- res_addr_i  in  A_REG  register to reserve
- res_tag_i  in  W_TAG  tag of the producing instruction
- wb_valid_i  in  1  writeback this cycle
- wb_addr_i  in  A_REG  writeback register
- wb_tag_i  in  W_TAG  writeback tag
- wb_data_i  in  W_DATA  writeback data
- flush_i  in  1  clear all reservations (pipeline flush)
- busy_cnt_o  out  W_CNT  number of registers currently reserved

Behaviour:
- Reset (rst=0, async): all data = 0, busy = 0, tags = 0, busy_cnt_o = 0.
- Register 0 is hardwired:
  - reads return 0 and busy = 0;
  - reservations and writebacks to address 0 are ignored and never counted.
- Reads are combinational from the current state, with zero latency. State updates are visible from the cycle after the clock edge.
- Reservation (res_valid_i, addr != 0): at the edge, busy[addr] <= 1 and tag[addr] <= res_tag_i. Re-reserving an already busy register overwrites the tag. The counter does not double-count.
- Writeback (wb_valid_i, addr != 0):
  - match = busy[addr] && tag[addr] == wb_tag_i.
  - Data is written if match, or if !busy[addr].
  - busy[addr] is cleared only on match.
  - A busy register with a tag mismatch is left unchanged: no data write, busy stays 1.
- Simultaneous reserve and writeback, same address:
  - the writeback is evaluated against the pre-edge state;
  - the reservation then wins: busy = 1, tag = res_tag_i;
  - data is written if the writeback qualified.
- Simultaneous reserve and writeback, different addresses: both are applied independently.
- flush_i: at the edge all busy bits clear. Data and tags are kept. A reservation in the same cycle is applied after the flush, so that register ends up busy. A writeback in the same cycle writes data only if its register was not busy or its tag matched.
- busy_cnt_o:
  - a registered count equal to the popcount of busy[N_REG-1:1], updated at the same edge;
  - the next value is computed from the next busy state;
  - it never exceeds N_REG-1 and never wraps.
- Any address/tag input with its valid low is don't-care.
- Reset asserted mid-operation clears all state immediately, regardless of the clock.

Optional Feature:
- Macro REGFILE_WB_BYPASS_EN.
- Defined: a read port whose address equals wb_addr_i (non-zero) in a cycle where the writeback qualifies (match, or register not busy) returns wb_data_i combinationally. If the writeback also clears busy, rd_busy_o for that port is 0.
- A same-cycle reservation of that register still takes effect next cycle.
- Undefined: reads reflect pre-edge state only, so the writeback is visible one cycle later.

Test Plan:
- Reset, then read r5 and r0 on both ports -> data 0, busy 0, busy_cnt_o 0. Write r0 with 0xFFFFFFFF (r0 not busy) -> r0 still reads 0.
- Reserve r3 with tag 2, then writeback r3 with tag 2 and data 0xDEADBEEF -> the cycle after the reserve: busy 1, tag 2, cnt 1. The cycle after the writeback: data 0xDEADBEEF, busy 0, cnt 0.
- Reserve r7 with tag 1, then reserve r7 with tag 4, then writeback r7 with tag 1 and data 0x11 -> busy stays 1, tag stays 4, data unchanged. Writeback r7 with tag 4 and data 0x22 -> data 0x22, busy 0.
- Same cycle: writeback r9 (not busy, data 0x55) and reserve r9 with tag 6 -> next cycle: data 0x55, busy 1, tag 6, cnt 1.
- Reserve r1, r2 and r4, then flush_i together with reserving r8 -> next cycle: only r8 busy, cnt 1, data of r1/r2/r4 unchanged.
- With REGFILE_WB_BYPASS_EN defined: writeback r3 (tag match, data 0xA5A5A5A5) while port 1 reads r3 -> same cycle: rd_data 0xA5A5A5A5, rd_busy 0. With the macro undefined -> same cycle shows the old data and busy 1.
